// File: rtl/cart_bus_arbiter.sv
// cart_bus_arbiter
//
// Shares the cartridge bus between the boy core and the UART debug requester.
// The core owns the bus while halt is low. While halt is high, the arbiter
// waits for the core to finish any strobe in progress and passes through a
// one-cycle TURN state. It then runs debug read/write transactions with fixed
// setup, strobe and hold timing.
//
// Parameters:
//   SETUP_CYC   cycles of address/data setup before the strobe (0 acts as 1)
//   STROBE_CYC  cycles bus_rd or bus_wr is held high (0 acts as 1)
//   HOLD_CYC    cycles address/data are held after the strobe (0 acts as 1)
//
// Ports:
//   clk, rst               clock and synchronous active-high reset
//   halt                   1 requests the bus for the debugger
//   core_a/core_dout       core address and write data
//   core_rd/core_wr        core strobes, active-high
//   dbg_req/dbg_we         debug request (held until ack) and direction
//   dbg_addr/dbg_wdata     debug address and write data
//   dbg_ack                one-cycle pulse when a debug transaction completes
//   dbg_rdata              debug read data, valid from dbg_ack onwards
//   bus_din                cartridge data in
//   bus_a/bus_dout         cartridge address and write data (registered)
//   bus_oe                 drive bus_dout onto the data pins
//   bus_rd/bus_wr/bus_cs   cartridge strobes and RAM chip select
//   dbg_owner              1 whenever the arbiter is not in CORE
module cart_bus_arbiter #(
    parameter int unsigned SETUP_CYC  = 2,
    parameter int unsigned STROBE_CYC = 6,
    parameter int unsigned HOLD_CYC   = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        halt,
    input  logic [15:0] core_a,
    input  logic [7:0]  core_dout,
    input  logic        core_rd,
    input  logic        core_wr,
    input  logic        dbg_req,
    input  logic        dbg_we,
    input  logic [15:0] dbg_addr,
    input  logic [7:0]  dbg_wdata,
    output logic        dbg_ack,
    output logic [7:0]  dbg_rdata,
    input  logic [7:0]  bus_din,
    output logic [15:0] bus_a,
    output logic [7:0]  bus_dout,
    output logic        bus_oe,
    output logic        bus_rd,
    output logic        bus_wr,
    output logic        bus_cs,
    output logic        dbg_owner
);

    // A zero phase length behaves as one cycle.
    localparam int unsigned SETUP_EFF  = (SETUP_CYC  == 0) ? 1 : SETUP_CYC;
    localparam int unsigned STROBE_EFF = (STROBE_CYC == 0) ? 1 : STROBE_CYC;
    localparam int unsigned HOLD_EFF   = (HOLD_CYC   == 0) ? 1 : HOLD_CYC;

    // The down-counter is loaded with length-1 and the phase ends when it reads 0.
    localparam logic [3:0] SETUP_LOAD  = 4'(SETUP_EFF - 1);
    localparam logic [3:0] STROBE_LOAD = 4'(STROBE_EFF - 1);
    localparam logic [3:0] HOLD_LOAD   = 4'(HOLD_EFF - 1);

    // Start of cartridge RAM; chip select only asserts at or above this address.
    localparam logic [15:0] RAM_BASE = 16'hA000;

    typedef enum logic [2:0] {
        CORE,
        TURN,
        D_IDLE,
        D_SETUP,
        D_STROBE,
        D_HOLD
    } state_t;

    state_t      state;
    state_t      state_n;
    logic [3:0]  cnt;
    logic [3:0]  cnt_n;
    logic        accept;

    logic        lat_we;
    logic [15:0] lat_addr;
    logic [7:0]  lat_wdata;

    logic        we_n;
    logic [15:0] addr_n;
    logic [7:0]  wdata_n;

    logic [15:0] bus_a_n;
    logic [7:0]  bus_dout_n;
    logic        bus_oe_n;
    logic        bus_rd_n;
    logic        bus_wr_n;
    logic        bus_cs_n;
    logic        dbg_ack_n;
    logic [7:0]  dbg_rdata_n;
    logic        dbg_owner_n;

    // State register. It also holds the phase counter and the request fields
    // latched when a debug transaction is accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= CORE;
            cnt       <= 4'd0;
            lat_we    <= 1'b0;
            lat_addr  <= 16'h0000;
            lat_wdata <= 8'h00;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            if (accept) begin
                lat_we    <= dbg_we;
                lat_addr  <= dbg_addr;
                lat_wdata <= dbg_wdata;
            end
        end
    end

    // Next-state logic. The core gives up the bus only in a cycle with no strobe,
    // so a core access is never cut short. In D_IDLE a pending request wins over
    // a falling halt.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        accept  = 1'b0;
        case (state)
            CORE: begin
                if (halt && !core_rd && !core_wr) begin
                    state_n = TURN;
                end
            end
            TURN: begin
                state_n = halt ? D_IDLE : CORE;
            end
            D_IDLE: begin
                if (dbg_req) begin
                    accept  = 1'b1;
                    state_n = D_SETUP;
                    cnt_n   = SETUP_LOAD;
                end else if (!halt) begin
                    state_n = TURN;
                end
            end
            D_SETUP: begin
                if (cnt == 4'd0) begin
                    state_n = D_STROBE;
                    cnt_n   = STROBE_LOAD;
                end else begin
                    cnt_n = cnt - 4'd1;
                end
            end
            D_STROBE: begin
                if (cnt == 4'd0) begin
                    state_n = D_HOLD;
                    cnt_n   = HOLD_LOAD;
                end else begin
                    cnt_n = cnt - 4'd1;
                end
            end
            D_HOLD: begin
                if (cnt == 4'd0) begin
                    state_n = D_IDLE;
                    cnt_n   = 4'd0;
                end else begin
                    cnt_n = cnt - 4'd1;
                end
            end
            default: begin
                state_n = CORE;
                cnt_n   = 4'd0;
            end
        endcase
    end

    // Output logic. It computes what the bus registers should hold in the state
    // being entered, so every bus output is a flop. On acceptance, the request
    // inputs are used directly because the latches update on the same edge.
    always_comb begin
        we_n        = accept ? dbg_we    : lat_we;
        addr_n      = accept ? dbg_addr  : lat_addr;
        wdata_n     = accept ? dbg_wdata : lat_wdata;

        bus_a_n     = bus_a;
        bus_dout_n  = bus_dout;
        bus_oe_n    = 1'b0;
        bus_rd_n    = 1'b0;
        bus_wr_n    = 1'b0;
        dbg_ack_n   = 1'b0;
        dbg_rdata_n = dbg_rdata;

        case (state_n)
            CORE: begin
                bus_a_n    = core_a;
                bus_dout_n = core_dout;
                bus_rd_n   = core_rd;
                bus_wr_n   = core_wr;
                bus_oe_n   = core_wr;
            end
            D_SETUP: begin
                bus_a_n    = addr_n;
                bus_dout_n = wdata_n;
                bus_oe_n   = we_n;
            end
            D_STROBE: begin
                bus_a_n    = addr_n;
                bus_dout_n = wdata_n;
                bus_oe_n   = we_n;
                bus_rd_n   = !we_n;
                bus_wr_n   = we_n;
            end
            D_HOLD: begin
                bus_a_n    = addr_n;
                bus_dout_n = wdata_n;
                bus_oe_n   = we_n;
                dbg_ack_n  = (cnt_n == 4'd0);
            end
            default: begin
                bus_oe_n = 1'b0;
            end
        endcase

        // Capture read data at the end of the final strobe cycle.
        if (state == D_STROBE && cnt == 4'd0 && !lat_we) begin
            dbg_rdata_n = bus_din;
        end

        bus_cs_n    = (bus_rd_n || bus_wr_n) && (bus_a_n >= RAM_BASE);
        dbg_owner_n = (state_n != CORE);
    end

    // Output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus_a     <= 16'h0000;
            bus_dout  <= 8'h00;
            bus_oe    <= 1'b0;
            bus_rd    <= 1'b0;
            bus_wr    <= 1'b0;
            bus_cs    <= 1'b0;
            dbg_ack   <= 1'b0;
            dbg_rdata <= 8'h00;
            dbg_owner <= 1'b0;
        end else begin
            bus_a     <= bus_a_n;
            bus_dout  <= bus_dout_n;
            bus_oe    <= bus_oe_n;
            bus_rd    <= bus_rd_n;
            bus_wr    <= bus_wr_n;
            bus_cs    <= bus_cs_n;
            dbg_ack   <= dbg_ack_n;
            dbg_rdata <= dbg_rdata_n;
            dbg_owner <= dbg_owner_n;
        end
    end

endmodule
